// File: rtl/dip_pkg.sv
// Shared types and defaults for the DiP systolic matmul: command kinds, sequencer states
// and the array/address sizes used by the datapath and PE array.
package dip_pkg;

  localparam int unsigned DipP     = 4;
  localparam int unsigned DipAddrW = 24;

  typedef enum logic [1:0] {
    CmdLdW = 2'd0,
    CmdLdA = 2'd1,
    CmdRdC = 2'd2,
    CmdWrC = 2'd3
  } cmd_kind_e;

  typedef enum logic [2:0] {
    StIdle,
    StWLoad,
    StAStream,
    StCRead,
    StCWrite,
    StFinish
  } state_e;

  // Command kind issued while the walker sits in a given state.
  function automatic cmd_kind_e state_kind(state_e st);
    cmd_kind_e kind;
    unique case (st)
      StAStream: kind = CmdLdA;
      StCRead:   kind = CmdRdC;
      StCWrite:  kind = CmdWrC;
      default:   kind = CmdLdW;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/dip_nest_cnt.sv
// One level of the tile loop nest: a wrap counter from 0 to limit_i, exposing the value it
// will hold after this cycle so the parent can register addresses for the next command.
module dip_nest_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         last_o
);

  logic [W-1:0] count_q, count_d;

  assign last_o  = (count_q == limit_i);
  // count_o is the index of the command presented after the coming edge.
  assign count_o = count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = last_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dip_tile_addr_gen.sv
// Tile walker for a PxP DiP array: loads weight tiles, streams A rows and reads/writes C
// rows, one registered memory command per handshake, looping j (K/P), i (N/P), h (M).
module dip_tile_addr_gen
  import dip_pkg::*;
#(
  parameter int unsigned P      = DipP,
  parameter int unsigned DIM_W  = 9,
  parameter int unsigned ADDR_W = DipAddrW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DIM_W-1:0]       M,
  input  logic [DIM_W-1:0]       N,
  input  logic [DIM_W-1:0]       K,
  input  logic [ADDR_W-1:0]      base_a,
  input  logic [ADDR_W-1:0]      base_w,
  input  logic [ADDR_W-1:0]      base_c,
  output logic                   busy,
  output logic                   done,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output cmd_kind_e              cmd_kind,
  output logic [ADDR_W-1:0]      cmd_addr,
  output logic [$clog2(P)-1:0]   cmd_row,
  output logic [$clog2(P)-1:0]   cmd_lane
);

  localparam int unsigned PW = $clog2(P);
  localparam logic [PW-1:0] PLast = PW'(P - 1);

  state_e            st_q, walk_st_d;
  logic [DIM_W-1:0]  m_q, n_q, k_q;
  logic [ADDR_W-1:0] ba_q, bw_q, bc_q;
  logic              busy_q, done_q, valid_q;
  cmd_kind_e         kind_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PW-1:0]     row_q, lane_q;

  logic              hs, start_ok, cnt_clr;
  logic              r_en, h_en, i_en, j_en;
  logic              c_last, r_last, h_last, i_last, j_last;
  logic [PW-1:0]     c_nxt, r_nxt;
  logic [DIM_W-1:0]  h_nxt, i_nxt, j_nxt;
  logic [DIM_W-1:0]  h_lim, i_lim, j_lim;
  logic [ADDR_W-1:0] i_off, j_off, c_off, r_off, h_ext, n_ext, k_ext;

  assign hs       = valid_q & cmd_ready;
  assign start_ok = start & ~abort & (st_q == StIdle);
  assign cnt_clr  = start_ok | abort;

  // Last flags chain inward-out: c wraps every P, r only in W_LOAD, h/i/j after a C row write.
  assign r_en = hs & (st_q == StWLoad) & c_last;
  assign h_en = hs & (st_q == StCWrite) & c_last;
  assign i_en = h_en & h_last;
  assign j_en = i_en & i_last;

  assign h_lim = m_q - DIM_W'(1);
  assign i_lim = (n_q >> PW) - DIM_W'(1);
  assign j_lim = (k_q >> PW) - DIM_W'(1);

  dip_nest_cnt #(.W(PW)) u_cnt_c (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (cnt_clr),
    .en_i    (hs),
    .limit_i (PLast),
    .count_o (c_nxt),
    .last_o  (c_last)
  );

  dip_nest_cnt #(.W(PW)) u_cnt_r (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (cnt_clr),
    .en_i    (r_en),
    .limit_i (PLast),
    .count_o (r_nxt),
    .last_o  (r_last)
  );

  dip_nest_cnt #(.W(DIM_W)) u_cnt_h (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (cnt_clr),
    .en_i    (h_en),
    .limit_i (h_lim),
    .count_o (h_nxt),
    .last_o  (h_last)
  );

  dip_nest_cnt #(.W(DIM_W)) u_cnt_i (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (cnt_clr),
    .en_i    (i_en),
    .limit_i (i_lim),
    .count_o (i_nxt),
    .last_o  (i_last)
  );

  dip_nest_cnt #(.W(DIM_W)) u_cnt_j (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (cnt_clr),
    .en_i    (j_en),
    .limit_i (j_lim),
    .count_o (j_nxt),
    .last_o  (j_last)
  );

  // State reached after a handshake in the current walk state.
  always_comb begin
    walk_st_d = st_q;
    if (c_last) begin
      unique case (st_q)
        StWLoad:   if (r_last) walk_st_d = StAStream;
        // The first reduction tile (i == 0) overwrites C, so no read-back.
        StAStream: walk_st_d = (i_nxt != '0) ? StCRead : StCWrite;
        StCRead:   walk_st_d = StCWrite;
        StCWrite: begin
          if (!h_last) begin
            walk_st_d = StAStream;
          end else if (i_last && j_last) begin
            walk_st_d = StFinish;
          end else begin
            walk_st_d = StWLoad;
          end
        end
        default: walk_st_d = st_q;
      endcase
    end
  end

  assign i_off = ADDR_W'(i_nxt) << PW;
  assign j_off = ADDR_W'(j_nxt) << PW;
  assign c_off = ADDR_W'(c_nxt);
  assign r_off = ADDR_W'(r_nxt);
  assign h_ext = ADDR_W'(h_nxt);
  assign n_ext = ADDR_W'(n_q);
  assign k_ext = ADDR_W'(k_q);

  always_comb begin
    unique case (walk_st_d)
      StWLoad:   addr_d = bw_q + (i_off + r_off) * k_ext + j_off + c_off;
      StAStream: addr_d = ba_q + h_ext * n_ext + i_off + c_off;
      default:   addr_d = bc_q + h_ext * k_ext + j_off + c_off;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      ba_q    <= '0;
      bw_q    <= '0;
      bc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      kind_q  <= CmdLdW;
      addr_q  <= '0;
      row_q   <= '0;
      lane_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        st_q    <= StIdle;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        unique case (st_q)
          StIdle: begin
            if (start) begin
              m_q    <= M;
              n_q    <= N;
              k_q    <= K;
              ba_q   <= base_a;
              bw_q   <= base_w;
              bc_q   <= base_c;
              busy_q <= 1'b1;
              if (M == '0 || N == '0 || K == '0) begin
                st_q <= StFinish;
              end else begin
                // First command is always the weight word at (i,j,r,c) = 0.
                st_q    <= StWLoad;
                valid_q <= 1'b1;
                kind_q  <= CmdLdW;
                addr_q  <= base_w;
                row_q   <= '0;
                lane_q  <= '0;
              end
            end
          end
          StFinish: begin
            st_q <= StIdle;
            // busy still high here only on the empty-walk path, which has not pulsed done yet.
            if (busy_q) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
          end
          default: begin
            if (hs) begin
              st_q <= walk_st_d;
              if (walk_st_d == StFinish) begin
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                kind_q <= state_kind(walk_st_d);
                addr_q <= addr_d;
                row_q  <= (walk_st_d == StWLoad) ? r_nxt : '0;
                lane_q <= c_nxt;
              end
            end
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_valid = valid_q;
  assign cmd_kind  = kind_q;
  assign cmd_addr  = addr_q;
  assign cmd_row   = row_q;
  assign cmd_lane  = lane_q;

endmodule
